// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: ALU op codes, forwarding selects and
// the multiply/divide sequencer states.
package cpu_pkg;

    typedef enum logic [4:0] {
        AluAdd   = 5'd0,
        AluSub   = 5'd1,
        AluAnd   = 5'd2,
        AluOr    = 5'd3,
        AluXor   = 5'd4,
        AluNor   = 5'd5,
        AluSlt   = 5'd6,
        AluSltu  = 5'd7,
        AluSll   = 5'd8,
        AluSrl   = 5'd9,
        AluSra   = 5'd10,
        AluMult  = 5'd11,
        AluMultu = 5'd12,
        AluDiv   = 5'd13,
        AluDivu  = 5'd14,
        AluMfhi  = 5'd15,
        AluMflo  = 5'd16,
        AluMthi  = 5'd17,
        AluMtlo  = 5'd18
    } alu_op_e;

    // 2'b11 is reserved and behaves like FwdReg.
    typedef enum logic [1:0] {
        FwdReg = 2'b00,
        FwdWb  = 2'b01,
        FwdMem = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MdIdle = 2'd0,
        MdRun  = 2'd1,
        MdDone = 2'd2
    } md_state_e;

    localparam logic [5:0] MdSteps = 6'd32;

    // Any op that touches HI/LO and therefore must wait for the iterative unit.
    function automatic logic is_md_op(input logic [4:0] code);
        return (code >= 5'(AluMult)) && (code <= 5'(AluMtlo));
    endfunction

    function automatic logic is_md_start(input logic [4:0] code);
        return (code >= 5'(AluMult)) && (code <= 5'(AluDivu));
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide engine owning HI/LO. One step per clock,
// sign correction applied in a final DONE cycle.
module muldiv_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  alu_control,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_busy,
    output logic        stall_md
);

    md_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        start, signed_in, signed_op, div_op, a_neg, b_neg;
    logic [31:0] mag_a_in, mag_b_in, quo, rem;
    logic [32:0] add_sum, sub_diff;
    logic [63:0] prod;

    assign start     = (state_q == MdIdle) && is_md_start(alu_control) && !stall_md;
    assign signed_in = (alu_control == AluMult) || (alu_control == AluDiv);
    assign mag_a_in  = (signed_in && src_a[31]) ? -src_a : src_a;
    assign mag_b_in  = (signed_in && src_b[31]) ? -src_b : src_b;

    assign signed_op = (op_q == AluMult) || (op_q == AluDiv);
    assign div_op    = (op_q == AluDiv) || (op_q == AluDivu);
    assign a_neg     = signed_op && a_q[31];
    assign b_neg     = signed_op && b_q[31];

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b_q} : 33'd0);
    assign sub_diff = acc_q[63:31] - {1'b0, mag_b_q};

    assign prod = (a_neg ^ b_neg) ? -acc_q : acc_q;
    assign quo  = (a_neg ^ b_neg) ? -acc_q[31:0] : acc_q[31:0];
    assign rem  = a_neg ? -acc_q[63:32] : acc_q[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MdIdle:  if (start) state_d = MdRun;
            MdRun:   if (cnt_q == 6'd1) state_d = MdDone;
            MdDone:  state_d = MdIdle;
            default: state_d = MdIdle;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        mag_b_d = mag_b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            MdIdle: begin
                if (start) begin
                    op_d    = alu_control;
                    a_d     = src_a;
                    b_d     = src_b;
                    mag_b_d = mag_b_in;
                    acc_d   = {32'd0, mag_a_in};
                    cnt_d   = MdSteps;
                end else if (!stall_md && alu_control == AluMthi) begin
                    hi_d = src_a;
                end else if (!stall_md && alu_control == AluMtlo) begin
                    lo_d = src_a;
                end
            end
            MdRun: begin
                cnt_d = cnt_q - 6'd1;
                if (!div_op) begin
                    acc_d = {add_sum, acc_q[31:1]};
                end else if (sub_diff[32]) begin
                    acc_d = {acc_q[62:0], 1'b0};
                end else begin
                    acc_d = {sub_diff[31:0], acc_q[30:0], 1'b1};
                end
            end
            MdDone: begin
                if (!div_op) begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end else if (b_q == 32'd0) begin
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        md_busy  = (state_q != MdIdle);
        stall_md = md_busy && is_md_op(alu_control);
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, immediate select, single-cycle ALU and the
// iterative HI/LO unit.
module execute_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  alu_control_e,
    input  logic        alu_src_e,
    input  logic        reg_dst_e,
    input  logic        upper_e,
    input  logic [31:0] read_data_1_e,
    input  logic [31:0] read_data_2_e,
    input  logic [31:0] sign_imm_e,
    input  logic [4:0]  rt_e,
    input  logic [4:0]  rd_e,
    input  logic [1:0]  forward_a_e,
    input  logic [1:0]  forward_b_e,
    input  logic [31:0] result_w,
    input  logic [31:0] alu_out_m,
    output logic [31:0] alu_out_e,
    output logic [31:0] write_data_e,
    output logic [4:0]  write_reg_e,
    output logic        md_busy,
    output logic        stall_md
);

    logic [31:0] src_a, fwd_b, src_b, hi, lo;
    logic [4:0]  shamt;

    always_comb begin
        unique case (forward_a_e)
            FwdWb:   src_a = result_w;
            FwdMem:  src_a = alu_out_m;
            default: src_a = read_data_1_e;
        endcase
        unique case (forward_b_e)
            FwdWb:   fwd_b = result_w;
            FwdMem:  fwd_b = alu_out_m;
            default: fwd_b = read_data_2_e;
        endcase
    end

    assign src_b        = alu_src_e ? sign_imm_e : fwd_b;
    assign shamt        = sign_imm_e[10:6];
    assign write_data_e = fwd_b;
    assign write_reg_e  = reg_dst_e ? rd_e : rt_e;

    always_comb begin
        alu_out_e = '0;
        if (upper_e) begin
            alu_out_e = {sign_imm_e[15:0], 16'h0000};
        end else begin
            case (alu_control_e)
                AluAdd:  alu_out_e = src_a + src_b;
                AluSub:  alu_out_e = src_a - src_b;
                AluAnd:  alu_out_e = src_a & src_b;
                AluOr:   alu_out_e = src_a | src_b;
                AluXor:  alu_out_e = src_a ^ src_b;
                AluNor:  alu_out_e = ~(src_a | src_b);
                AluSlt:  alu_out_e = {31'd0, $signed(src_a) < $signed(src_b)};
                AluSltu: alu_out_e = {31'd0, src_a < src_b};
                AluSll:  alu_out_e = src_b << shamt;
                AluSrl:  alu_out_e = src_b >> shamt;
                AluSra:  alu_out_e = $signed(src_b) >>> shamt;
                AluMfhi: alu_out_e = hi;
                AluMflo: alu_out_e = lo;
                default: alu_out_e = '0;
            endcase
        end
    end

    muldiv_unit u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .alu_control (alu_control_e),
        .src_a       (src_a),
        .src_b       (src_b),
        .hi          (hi),
        .lo          (lo),
        .md_busy     (md_busy),
        .stall_md    (stall_md)
    );

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized checks of execute_stage against an arithmetic reference model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  alu_control_e;
    logic        alu_src_e, reg_dst_e, upper_e;
    logic [31:0] read_data_1_e, read_data_2_e, sign_imm_e;
    logic [4:0]  rt_e, rd_e;
    logic [1:0]  forward_a_e, forward_b_e;
    logic [31:0] result_w, alu_out_m;
    logic [31:0] alu_out_e, write_data_e;
    logic [4:0]  write_reg_e;
    logic        md_busy, stall_md;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk           (clk),
        .rst           (rst),
        .alu_control_e (alu_control_e),
        .alu_src_e     (alu_src_e),
        .reg_dst_e     (reg_dst_e),
        .upper_e       (upper_e),
        .read_data_1_e (read_data_1_e),
        .read_data_2_e (read_data_2_e),
        .sign_imm_e    (sign_imm_e),
        .rt_e          (rt_e),
        .rd_e          (rd_e),
        .forward_a_e   (forward_a_e),
        .forward_b_e   (forward_b_e),
        .result_w      (result_w),
        .alu_out_m     (alu_out_m),
        .alu_out_e     (alu_out_e),
        .write_data_e  (write_data_e),
        .write_reg_e   (write_reg_e),
        .md_busy       (md_busy),
        .stall_md      (stall_md)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v);
        if (sel == 2'b01) return result_w;
        if (sel == 2'b10) return alu_out_m;
        return reg_v;
    endfunction

    // Reference ALU from the op table, in plain integer arithmetic.
    function automatic logic [31:0] model_alu(input int op, input logic [31:0] a,
                                              input logic [31:0] b, input int sh);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        case (op)
            0:  return a + b;
            1:  return a + (~b) + 32'd1;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ~(a | b);
            6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            7:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            8:  return b * (32'd1 << sh);
            9:  return b / (32'd1 << sh);
            10: return (b >> sh) | (b[31] ? ~(ones >> sh) : 32'd0);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_md(input int op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi_e, output logic [31:0] lo_e);
        longint          ps;
        longint unsigned pu;
        case (op)
            11: begin
                ps = longint'(int'(a)) * longint'(int'(b));
                hi_e = ps[63:32]; lo_e = ps[31:0];
            end
            12: begin
                pu = {32'd0, a} * {32'd0, b};
                hi_e = pu[63:32]; lo_e = pu[31:0];
            end
            13: begin
                if (b == 0) begin hi_e = a; lo_e = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    hi_e = 32'd0; lo_e = 32'h8000_0000;
                end else begin
                    lo_e = int'(a) / int'(b);
                    hi_e = int'(a) % int'(b);
                end
            end
            default: begin
                if (b == 0) begin hi_e = a; lo_e = 32'hFFFF_FFFF; end
                else begin lo_e = a / b; hi_e = a % b; end
            end
        endcase
    endtask

    task automatic drive_plain(input int op, input logic [31:0] a, input logic [31:0] b);
        alu_control_e = 5'(op);
        read_data_1_e = a;
        read_data_2_e = b;
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        alu_src_e = 1'b0;
        upper_e = 1'b0;
    endtask

    // Presents MFLO until the stall drops (bounded), then checks LO and HI.
    task automatic finish_md(input string tag, input int op, input logic [31:0] a,
                             input logic [31:0] b, output int stalls);
        logic [31:0] hi_e, lo_e;
        model_md(op, a, b, hi_e, lo_e);
        alu_control_e = 5'd16;
        #1;
        stalls = 0;
        while (stall_md && stalls < 100) begin
            stalls++;
            tick();
        end
        check({tag, "_lo"}, alu_out_e, lo_e);
        alu_control_e = 5'd15;
        #1;
        check({tag, "_hi"}, alu_out_e, hi_e);
        alu_control_e = 5'd0;
    endtask

    task automatic run_md(input string tag, input int op, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        drive_plain(op, a, b);
        tick();
        check({tag, "_busy"}, {31'd0, md_busy}, 32'd1);
        finish_md(tag, op, a, b, n);
        check({tag, "_stalls"}, n, 33);
    endtask

    initial begin
        logic [31:0] a, b, exp_v, sa, fb, sb;
        int op, sh, n;

        drive_plain(0, 32'd3, 32'd4);
        sign_imm_e = 32'd0; reg_dst_e = 1'b0; rt_e = 5'd0; rd_e = 5'd0;
        result_w = 32'd0; alu_out_m = 32'd0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_comb_add", alu_out_e, 32'd7);
        check("rst_busy", {31'd0, md_busy}, 32'd0);
        rst = 1'b0;
        alu_control_e = 5'd15;
        #1;
        check("rst_stall", {31'd0, stall_md}, 32'd0);
        check("rst_hi", alu_out_e, 32'd0);
        alu_control_e = 5'd16;
        #1;
        check("rst_lo", alu_out_e, 32'd0);

        drive_plain(0, 32'd7, 32'd99);
        forward_b_e = 2'b10; alu_out_m = 32'd5;
        #1;
        check("fwd_add", alu_out_e, 32'd12);
        check("fwd_wdata", write_data_e, 32'd5);

        drive_plain(10, 32'd0, 32'h8000_0000);
        sign_imm_e = 32'd4 << 6;
        #1;
        check("sra_min", alu_out_e, 32'hF800_0000);
        upper_e = 1'b1; sign_imm_e = 32'h0000_1234;
        #1;
        check("lui", alu_out_e, 32'h1234_0000);

        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 10));
            alu_control_e = 5'(op);
            read_data_1_e = $urandom; read_data_2_e = $urandom;
            result_w = $urandom; alu_out_m = $urandom; sign_imm_e = $urandom;
            forward_a_e = 2'($urandom_range(0, 3)); forward_b_e = 2'($urandom_range(0, 3));
            alu_src_e = 1'($urandom_range(0, 1)); reg_dst_e = 1'($urandom_range(0, 1));
            upper_e = ($urandom_range(0, 7) == 0);
            rt_e = 5'($urandom); rd_e = 5'($urandom);
            #1;
            sa = pick(forward_a_e, read_data_1_e);
            fb = pick(forward_b_e, read_data_2_e);
            sb = alu_src_e ? sign_imm_e : fb;
            sh = int'(sign_imm_e[10:6]);
            exp_v = upper_e ? (sign_imm_e << 16) : model_alu(op, sa, sb, sh);
            check($sformatf("rand_alu_op%0d", op), alu_out_e, exp_v);
            check("rand_wdata", write_data_e, fb);
            check("rand_wreg", {27'd0, write_reg_e}, {27'd0, reg_dst_e ? rd_e : rt_e});
        end

        // Undefined codes and HI/LO-only codes read back 0 (no clock edge here).
        for (int c = 11; c < 32; c++) begin
            if (c == 15 || c == 16) continue;
            drive_plain(c, 32'h1111_2222, 32'h3333_4444);
            #1;
            check($sformatf("zero_code%0d", c), alu_out_e, 32'd0);
        end
        drive_plain(0, 32'd0, 32'd0);
        tick();

        run_md("mult_neg3x7", 11, 32'hFFFF_FFFD, 32'd7);
        run_md("div_neg7by2", 13, 32'hFFFF_FFF9, 32'd2);
        run_md("divu_by0", 14, 32'd9, 32'd0);
        run_md("div_ovf", 13, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("div_neg_by0", 13, 32'hFFFF_FF00, 32'd0);
        for (int i = 0; i < 8; i++) begin
            op = int'($urandom_range(11, 14));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i < 4 && op >= 13) b = $urandom_range(1, 300);
            run_md($sformatf("md_rand%0d_op%0d", i, op), op, a, b);
        end

        // Independent ALU work proceeds while a MULT is running.
        drive_plain(11, 32'd123456, 32'hFFFF_FCEB);
        tick();
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom;
            drive_plain(0, a, b);
            #1;
            check("overlap_stall", {31'd0, stall_md}, 32'd0);
            check("overlap_add", alu_out_e, a + b);
            tick();
        end
        finish_md("overlap_mult", 11, 32'd123456, 32'hFFFF_FCEB, n);

        // MTHI/MTLO then a reset that abandons an in-flight MULT.
        drive_plain(18, 32'hCAFE_0001, 32'd0);
        tick();
        drive_plain(17, 32'd5, 32'd0);
        tick();
        alu_control_e = 5'd15;
        #1;
        check("mthi", alu_out_e, 32'd5);
        alu_control_e = 5'd16;
        #1;
        check("mtlo", alu_out_e, 32'hCAFE_0001);
        drive_plain(11, 32'd1000, 32'd1000);
        tick();
        alu_control_e = 5'd0;
        repeat (9) tick();
        check("pre_rst_busy", {31'd0, md_busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, md_busy}, 32'd0);
        alu_control_e = 5'd15;
        #1;
        check("abort_hi", alu_out_e, 32'd0);
        alu_control_e = 5'd0;
        repeat (40) tick();
        alu_control_e = 5'd15;
        #1;
        check("abort_no_late_hi", alu_out_e, 32'd0);
        alu_control_e = 5'd16;
        #1;
        check("abort_no_late_lo", alu_out_e, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
